// File: rtl/timebase_pkg.sv
// Shared constants and timer state encoding for the CLK_21MHZ timebase.
package timebase_pkg;

  localparam int US_DIV_DEFAULT    = 21;
  localparam int MS_DIV_DEFAULT    = 1000;
  localparam int S_DIV_DEFAULT     = 1000;
  localparam int TS_WIDTH_DEFAULT  = 32;
  localparam int TMR_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    EXPIRE = 2'd2
  } tmr_state_e;

  // Counter width for a 0..div-1 wrap counter; never narrower than one bit.
  function automatic int cnt_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Wrap counter 0..DIV-1 with count enable, combinational carry (wrap) for
// cascading and a registered one-cycle tick that follows the wrap.
module tick_divider
  import timebase_pkg::*;
#(
  parameter int DIV = US_DIV_DEFAULT,
  localparam int CW = cnt_width(DIV)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          wrap,
  output logic          tick,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    wrap   = en && (cnt_q == LAST);
    cnt_d  = cnt_q;
    tick_d = wrap;
    if (en) begin
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
  assign cnt  = cnt_q;

endmodule

// File: rtl/timebase_gen.sv
// 1 us / 1 ms / 1 s enable strobes, microsecond timestamp with latch and a
// one-shot microsecond timer. TIMEBASE_SQUARE_OUT_EN adds the CLK_1MHZ_SQ level output.
module timebase_gen
  import timebase_pkg::*;
#(
  parameter int US_DIV    = US_DIV_DEFAULT,
  parameter int MS_DIV    = MS_DIV_DEFAULT,
  parameter int S_DIV     = S_DIV_DEFAULT,
  parameter int TS_WIDTH  = TS_WIDTH_DEFAULT,
  parameter int TMR_WIDTH = TMR_WIDTH_DEFAULT
) (
  input  logic                 CLK_21MHZ,
  input  logic                 RST,
  input  logic                 EN,
  output logic                 US_TICK,
  output logic                 MS_TICK,
  output logic                 S_TICK,
  output logic [TS_WIDTH-1:0]  TIMESTAMP,
  input  logic                 LATCH_REQ,
  output logic [TS_WIDTH-1:0]  TS_LATCHED,
  output logic                 TS_VALID,
  input  logic                 TMR_LOAD,
  input  logic [TMR_WIDTH-1:0] TMR_VALUE,
  output logic                 TMR_BUSY,
  output logic                 TMR_DONE
`ifdef TIMEBASE_SQUARE_OUT_EN
  ,
  output logic                 CLK_1MHZ_SQ
`endif
);

  localparam int US_CW = cnt_width(US_DIV);
  localparam int MS_CW = cnt_width(MS_DIV);
  localparam int S_CW  = cnt_width(S_DIV);

  logic             us_wrap, ms_wrap, s_wrap;
  logic             us_tick, ms_tick, s_tick;
  logic [US_CW-1:0] us_cnt;
  logic [MS_CW-1:0] ms_cnt;
  logic [S_CW-1:0]  s_cnt;

  // Stages cascade on the combinational carry so MS/S ticks coincide with US_TICK.
  tick_divider #(.DIV(US_DIV)) u_us (
    .clk(CLK_21MHZ), .rst(RST), .en(EN),
    .wrap(us_wrap), .tick(us_tick), .cnt(us_cnt)
  );

  tick_divider #(.DIV(MS_DIV)) u_ms (
    .clk(CLK_21MHZ), .rst(RST), .en(us_wrap),
    .wrap(ms_wrap), .tick(ms_tick), .cnt(ms_cnt)
  );

  tick_divider #(.DIV(S_DIV)) u_s (
    .clk(CLK_21MHZ), .rst(RST), .en(ms_wrap),
    .wrap(s_wrap), .tick(s_tick), .cnt(s_cnt)
  );

  logic cnt_unused;
  assign cnt_unused = ^{us_cnt, ms_cnt, s_cnt, s_wrap};

  assign US_TICK = us_tick;
  assign MS_TICK = ms_tick;
  assign S_TICK  = s_tick;

  // A microsecond is consumed while US_TICK is high, unless the timebase is frozen.
  logic tick_en;
  assign tick_en = us_tick & EN;

  logic [TS_WIDTH-1:0] ts_q, ts_d, ts_lat_q, ts_lat_d;
  logic                ts_vld_q, ts_vld_d;

  always_comb begin
    ts_d     = tick_en ? ts_q + TS_WIDTH'(1) : ts_q;
    ts_lat_d = LATCH_REQ ? ts_q : ts_lat_q;
    ts_vld_d = LATCH_REQ;
  end

  always_ff @(posedge CLK_21MHZ) begin
    if (RST) begin
      ts_q     <= '0;
      ts_lat_q <= '0;
      ts_vld_q <= 1'b0;
    end else begin
      ts_q     <= ts_d;
      ts_lat_q <= ts_lat_d;
      ts_vld_q <= ts_vld_d;
    end
  end

  assign TIMESTAMP  = ts_q;
  assign TS_LATCHED = ts_lat_q;
  assign TS_VALID   = ts_vld_q;

  tmr_state_e           state_q, state_d;
  logic [TMR_WIDTH-1:0] rem_q, rem_d;

  always_ff @(posedge CLK_21MHZ) begin
    if (RST) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // A load wins over everything, including a coincident tick and a pending expiry.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (TMR_LOAD) begin
      rem_d   = TMR_VALUE;
      state_d = (TMR_VALUE == '0) ? EXPIRE : RUN;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          if (tick_en) begin
            rem_d = rem_q - TMR_WIDTH'(1);
            if (rem_q == TMR_WIDTH'(1)) state_d = EXPIRE;
          end
        end
        EXPIRE:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    TMR_BUSY = 1'b0;
    TMR_DONE = 1'b0;
    case (state_q)
      RUN:     TMR_BUSY = 1'b1;
      EXPIRE:  TMR_DONE = 1'b1;
      default: ;
    endcase
  end

`ifdef TIMEBASE_SQUARE_OUT_EN
  localparam int SQ_HIGH = (US_DIV + 1) / 2;

  logic sq_q, sq_d;

  // Registered from the next us_cnt value so the level tracks us_cnt without lag.
  always_comb begin
    sq_d = sq_q;
    if (EN) sq_d = us_wrap || ((int'(us_cnt) + 1) < SQ_HIGH);
  end

  always_ff @(posedge CLK_21MHZ) begin
    if (RST) sq_q <= 1'b0;
    else     sq_q <= sq_d;
  end

  assign CLK_1MHZ_SQ = sq_q;
`endif

endmodule

// File: tb/tb_timebase_gen.sv
// Directed bench for timebase_gen with US_DIV=21, MS_DIV=4, S_DIV=3.
// Build with TIMEBASE_SQUARE_OUT_EN defined to also cover CLK_1MHZ_SQ.
module tb_timebase_gen;

  localparam int US_DIV = 21;
  localparam int MS_DIV = 4;
  localparam int S_DIV  = 3;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        EN = 1'b0;
  logic        US_TICK, MS_TICK, S_TICK;
  logic [31:0] TIMESTAMP, TS_LATCHED;
  logic        LATCH_REQ = 1'b0;
  logic        TS_VALID;
  logic        TMR_LOAD = 1'b0;
  logic [15:0] TMR_VALUE = '0;
  logic        TMR_BUSY, TMR_DONE;
`ifdef TIMEBASE_SQUARE_OUT_EN
  logic        CLK_1MHZ_SQ;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  timebase_gen #(
    .US_DIV(US_DIV), .MS_DIV(MS_DIV), .S_DIV(S_DIV), .TS_WIDTH(32), .TMR_WIDTH(16)
  ) dut (
    .CLK_21MHZ(clk), .RST(RST), .EN(EN),
    .US_TICK(US_TICK), .MS_TICK(MS_TICK), .S_TICK(S_TICK),
    .TIMESTAMP(TIMESTAMP), .LATCH_REQ(LATCH_REQ),
    .TS_LATCHED(TS_LATCHED), .TS_VALID(TS_VALID),
    .TMR_LOAD(TMR_LOAD), .TMR_VALUE(TMR_VALUE),
    .TMR_BUSY(TMR_BUSY), .TMR_DONE(TMR_DONE)
`ifdef TIMEBASE_SQUARE_OUT_EN
    , .CLK_1MHZ_SQ(CLK_1MHZ_SQ)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic clk_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          m;
    logic        us_prev, us_exp, ms_exp, s_exp, seen;
    logic [31:0] ts_exp;

    // Reset dominates even with EN high.
    RST = 1'b1;
    EN  = 1'b1;
    repeat (3) clk_edge();
    check_val("rst_us_tick", US_TICK, 0);
    check_val("rst_ms_tick", MS_TICK, 0);
    check_val("rst_s_tick", S_TICK, 0);
    check_val("rst_timestamp", TIMESTAMP, 0);
    check_val("rst_ts_latched", TS_LATCHED, 0);
    check_val("rst_ts_valid", TS_VALID, 0);
    check_val("rst_busy", TMR_BUSY, 0);
    check_val("rst_done", TMR_DONE, 0);
`ifdef TIMEBASE_SQUARE_OUT_EN
    check_val("rst_sq", CLK_1MHZ_SQ, 0);
`endif
    RST = 1'b0;

    // Divider chain, EN gap at edges 261..267, latch requests at 127, 130, 131.
    m       = 0;
    us_prev = 1'b0;
    ts_exp  = '0;
    for (int n = 1; n <= 300; n++) begin
      EN        = (n >= 261 && n <= 267) ? 1'b0 : 1'b1;
      LATCH_REQ = (n == 127 || n == 130 || n == 131);
      clk_edge();
      if (EN) begin
        if (us_prev) ts_exp = ts_exp + 32'd1;
        m++;
      end
      us_exp = EN && (m % US_DIV == 0);
      ms_exp = us_exp && (m % (US_DIV * MS_DIV) == 0);
      s_exp  = us_exp && (m % (US_DIV * MS_DIV * S_DIV) == 0);
      check_val($sformatf("us_tick@%0d", n), US_TICK, us_exp);
      check_val($sformatf("ms_tick@%0d", n), MS_TICK, ms_exp);
      check_val($sformatf("s_tick@%0d", n), S_TICK, s_exp);
      check_val($sformatf("timestamp@%0d", n), TIMESTAMP, ts_exp);
      check_val($sformatf("ts_valid@%0d", n), TS_VALID,
                (n == 127 || n == 130 || n == 131));
`ifdef TIMEBASE_SQUARE_OUT_EN
      check_val($sformatf("sq@%0d", n), CLK_1MHZ_SQ, ((m % US_DIV) < 11));
`endif
      if (n == 127) begin
        check_val("latch_on_tick_value", TS_LATCHED, 5);
        check_val("latch_on_tick_ts_after", TIMESTAMP, 6);
      end
      if (n == 131) check_val("latch_back_to_back", TS_LATCHED, 6);
      if (n == 252) check_val("s_tick_at_252", S_TICK, 1);
      if (n == 273) check_val("gap_no_early_tick", US_TICK, 0);
      if (n == 280) check_val("gap_delayed_tick", US_TICK, 1);
      us_prev = us_exp;
    end
    LATCH_REQ = 1'b0;
    EN        = 1'b1;

    // Timestamp wrap from all-ones.
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      clk_edge();
      seen = US_TICK;
    end
    check_val("wrap_tick_seen", seen, 1);
    force dut.ts_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.ts_q;
    check_val("ts_preload", TIMESTAMP, 32'hFFFF_FFFF);
    clk_edge();
    check_val("ts_wrap_to_zero", TIMESTAMP, 0);

    // Timer: loads at 22 (3, tick-coincident), 88 (0), 92 (5), 150 (10, reload), 370 (4); RST at 400.
    RST = 1'b1;
    clk_edge();
    RST = 1'b0;
    for (int n = 1; n <= 500; n++) begin
      RST       = (n == 400);
      TMR_LOAD  = 1'b1;
      case (n)
        22:      TMR_VALUE = 16'd3;
        88:      TMR_VALUE = 16'd0;
        92:      TMR_VALUE = 16'd5;
        150:     TMR_VALUE = 16'd10;
        370:     TMR_VALUE = 16'd4;
        default: begin TMR_LOAD = 1'b0; TMR_VALUE = 16'hFFFF; end
      endcase
      clk_edge();
      check_val($sformatf("tmr_busy@%0d", n), TMR_BUSY,
                (n >= 22 && n <= 84) || (n >= 92 && n <= 357) || (n >= 370 && n < 400));
      check_val($sformatf("tmr_done@%0d", n), TMR_DONE,
                (n == 85 || n == 88 || n == 358));
      if (n == 400) begin
        check_val("rst_mid_run_us_tick", US_TICK, 0);
        check_val("rst_mid_run_ts", TIMESTAMP, 0);
      end
    end
    TMR_LOAD = 1'b0;
    RST      = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
